// File: rtl/fsm_countdown.sv
// Loadable minutes:seconds countdown timer. It decrements once per external
// one-second tick while running and pulses done for one cycle on reaching 00:00.
module fsm_countdown #(
   parameter int unsigned MAX_VAL = 59
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       load,
   input  logic [5:0] min_in,
   input  logic [5:0] sec_in,
   input  logic       start,
   input  logic       pause,
   output logic [5:0] min_out,
   output logic [5:0] sec_out,
   output logic       running,
   output logic       done,
   output logic       err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [5:0] MAX6 = 6'(MAX_VAL);

   state_t     state, state_n;
   logic [5:0] min_n, sec_n;
   logic       done_n, err_n;
   logic       load_ok, count_zero;

   assign load_ok    = (min_in <= MAX6) && (sec_in <= MAX6);
   assign count_zero = (min_out == 6'd0) && (sec_out == 6'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         min_out <= 6'd0;
         sec_out <= 6'd0;
         running <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         state   <= state_n;
         min_out <= min_n;
         sec_out <= sec_n;
         running <= (state_n == RUN);
         done    <= done_n;
         err     <= err_n;
      end
   end

   always_comb begin
      state_n = state;
      min_n   = min_out;
      sec_n   = sec_out;
      done_n  = 1'b0;
      err_n   = err;
      case (state)
         RUN: begin
            // A load request in RUN is dropped but still claims the cycle,
            // so the tick that shares it is not counted.
            if (load) begin
               state_n = RUN;
            end else if (pause) begin
               state_n = PAUSE;
            end else if (tick) begin
               if (sec_out != 6'd0) begin
                  sec_n = sec_out - 6'd1;
               end else if (min_out != 6'd0) begin
                  sec_n = MAX6;
                  min_n = min_out - 6'd1;
               end
               if ((min_n == 6'd0) && (sec_n == 6'd0)) begin
                  state_n = DONE;
                  done_n  = 1'b1;
               end
            end
         end
         IDLE, PAUSE, DONE: begin
            if (load) begin
               if (load_ok) begin
                  min_n   = min_in;
                  sec_n   = sec_in;
                  err_n   = 1'b0;
                  state_n = IDLE;
               end else begin
                  err_n = 1'b1;
               end
            end else if (pause) begin
               state_n = state;
            end else if (start) begin
               if (state == PAUSE) begin
                  state_n = RUN;
               end else if ((state == IDLE) && !count_zero) begin
                  state_n = RUN;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_fsm_countdown.sv
// Self-checking bench for fsm_countdown: a total-seconds reference model feeds
// a scoreboard queue that a monitor drains one cycle after each edge.
module tb_fsm_countdown;

   localparam int unsigned MAX_VAL = 59;
   localparam int BASE = MAX_VAL + 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick = 1'b0;
   logic       load = 1'b0;
   logic [5:0] min_in = 6'd0;
   logic [5:0] sec_in = 6'd0;
   logic       start = 1'b0;
   logic       pause = 1'b0;
   logic [5:0] min_out, sec_out;
   logic       running, done, err;

   fsm_countdown #(.MAX_VAL(MAX_VAL)) dut (
      .clk(clk), .rst(rst), .tick(tick), .load(load),
      .min_in(min_in), .sec_in(sec_in), .start(start), .pause(pause),
      .min_out(min_out), .sec_out(sec_out), .running(running),
      .done(done), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0] mn;
      logic [5:0] sc;
      logic       run;
      logic       dn;
      logic       er;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: the count is a single number of seconds remaining.
   int   m_total = 0;
   bit   m_run = 0, m_pause = 0, m_done = 0, m_err = 0, m_pulse = 0;

   task automatic modelStep(input bit r, input bit tk, input bit ld,
                            input int mi, input int si, input bit st, input bit pa);
      bit idle;
      idle    = !m_run && !m_pause && !m_done;
      m_pulse = 0;
      if (r) begin
         m_total = 0; m_run = 0; m_pause = 0; m_done = 0; m_err = 0;
      end else if (ld) begin
         if (!m_run) begin
            if (mi <= int'(MAX_VAL) && si <= int'(MAX_VAL)) begin
               m_total = mi * BASE + si;
               m_err = 0; m_run = 0; m_pause = 0; m_done = 0;
            end else begin
               m_err = 1;
            end
         end
      end else if (pa) begin
         if (m_run) begin m_run = 0; m_pause = 1; end
      end else if (st && (idle || m_pause)) begin
         if (m_pause || m_total != 0) begin m_run = 1; m_pause = 0; end
      end else if (tk && m_run) begin
         m_total = m_total - 1;
         if (m_total == 0) begin m_run = 0; m_done = 1; m_pulse = 1; end
      end
   endtask

   task automatic applyStimulus(input bit r, input bit tk, input bit ld,
                                input int mi, input int si, input bit st, input bit pa);
      exp_t e;
      @(negedge clk);
      rst = r; tick = tk; load = ld; start = st; pause = pa;
      min_in = 6'(mi); sec_in = 6'(si);
      modelStep(r, tk, ld, mi, si, st, pa);
      e.mn  = 6'(m_total / BASE);
      e.sc  = 6'(m_total % BASE);
      e.run = m_run;
      e.dn  = m_pulse;
      e.er  = m_err;
      exp_q.push_back(e);
   endtask

   task automatic checkOutput(input exp_t e);
      checks += 5;
      if (min_out !== e.mn) begin
         errors++; $display("[TB] FAIL min_out got %0d want %0d at %0t", min_out, e.mn, $time);
      end
      if (sec_out !== e.sc) begin
         errors++; $display("[TB] FAIL sec_out got %0d want %0d at %0t", sec_out, e.sc, $time);
      end
      if (running !== e.run) begin
         errors++; $display("[TB] FAIL running got %b want %b at %0t", running, e.run, $time);
      end
      if (done !== e.dn) begin
         errors++; $display("[TB] FAIL done got %b want %b at %0t", done, e.dn, $time);
      end
      if (err !== e.er) begin
         errors++; $display("[TB] FAIL err got %b want %b at %0t", err, e.er, $time);
      end
   endtask

   // Monitor: every edge produces one registered response to compare.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
   end

   task automatic idleCycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      // Reset and full countdown from 01:02 with borrow and done pulse.
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 1, 1, 5, 5, 1, 0);
      applyStimulus(0, 0, 1, 1, 2, 0, 0);
      applyStimulus(0, 1, 0, 0, 0, 1, 0);
      for (int i = 0; i < 65; i++) applyStimulus(0, 1, 0, 0, 0, 0, 0);

      // Pause together with the second tick, then resume.
      applyStimulus(0, 0, 1, 0, 3, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 1, 0);
      applyStimulus(0, 1, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 1, 0);
      applyStimulus(0, 1, 0, 0, 0, 0, 0);

      // Out-of-range load keeps the count and sets err; a valid one clears it.
      applyStimulus(0, 0, 1, 0, 10, 0, 0);
      applyStimulus(0, 0, 1, 60, 5, 0, 0);
      idleCycle();
      applyStimulus(0, 0, 1, 0, 5, 1, 0);
      applyStimulus(0, 0, 1, 63, 63, 0, 0);

      // Load ignored in RUN, even alongside a tick.
      applyStimulus(0, 0, 1, 0, 45, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 1, 0, 7, 0, 0);
      applyStimulus(0, 1, 1, 0, 7, 0, 0);
      applyStimulus(0, 1, 0, 0, 0, 1, 0);

      // Start on 00:00 does nothing.
      applyStimulus(0, 0, 1, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0, 1, 0);
      idleCycle();

      // Reset mid-count together with a tick.
      applyStimulus(0, 0, 1, 0, 31, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 1, 0);
      applyStimulus(0, 1, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0, 0, 0);
      applyStimulus(1, 1, 0, 0, 0, 0, 0);
      idleCycle();

      // Randomized traffic with short counts so DONE is reached often.
      for (int i = 0; i < 4000; i++) begin
         bit r, tk, ld, st, pa;
         int mi, si;
         r  = ($urandom_range(0, 299) == 0);
         ld = ($urandom_range(0, 24) == 0);
         st = ($urandom_range(0, 7) == 0);
         pa = ld ? 1'b0 : ($urandom_range(0, 29) == 0);
         tk = ($urandom_range(0, 1) == 1);
         if ($urandom_range(0, 7) == 0) begin
            mi = $urandom_range(0, 63); si = $urandom_range(0, 63);
         end else begin
            mi = $urandom_range(0, 1);  si = $urandom_range(0, 59);
         end
         applyStimulus(r, tk, ld, mi, si, st, pa);
      end

      idleCycle();
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
